// File: rtl/mc_mem_responder.sv
// mc_mem_responder
//   Unified instruction/data memory responder for the multi-cycle RV32I core.
//   Accepts one request at a time and inserts WAIT_CYCLES wait states. It then
//   performs a word read or a byte-enabled write, and returns a response.
//   A misaligned or out-of-range access sets rsp_err and never modifies storage.
//
// Ports
//   clk, rstn        clock (rising edge), synchronous active-low reset
//   req_valid/ready  request handshake (ready only in IDLE)
//   req_write        1 = store, 0 = load/fetch
//   req_addr         byte address
//   req_wdata        store data
//   req_be           byte enables, bit i -> lane [8i+7:8i]
//   rsp_valid/ready  response handshake
//   rsp_rdata        read data (0 for writes and errors)
//   rsp_err          misaligned or out-of-range access
module mc_mem_responder #(
    parameter int DEPTH_WORDS = 1024,  // power of two, >= 4
    parameter int WAIT_CYCLES = 2      // 0..15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic             acc_err;
    logic             mem_we;

    assign idx = addr_q[IDX_W+1:2];
    // Any set bit above the index field means word index >= DEPTH_WORDS;
    // such addresses are errors and never alias onto lower words.
    assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q[31:IDX_W+2] != '0);
    assign mem_we  = rstn && (state_q == S_ACCESS) && wr_q && !acc_err;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // <= guards the unreachable count of 0 from hanging here
                if (cnt_q <= 4'd1) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                err_d   = acc_err;
                rdata_d = (acc_err || wr_q) ? 32'h0 : mem[idx];
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside reset so completed writes survive it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mc_mem_responder.sv
module tb_mc_mem_responder;

    // Instance 0: WAIT_CYCLES=2, DEPTH 1024. Instance 1: WAIT_CYCLES=0, DEPTH 16.
    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction
    function automatic int depth(input int d);
        return (d == 0) ? 1024 : 16;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rstn[2], req_valid[2], req_ready[2], req_write[2];
    logic        rsp_valid[2], rsp_ready[2], rsp_err[2];
    logic [31:0] req_addr[2], req_wdata[2], rsp_rdata[2];
    logic [3:0]  req_be[2];

    mc_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rstn(rstn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_be(req_be[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    mc_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rstn(rstn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_be(req_be[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    int checks = 0;
    int fails  = 0;

    // Reference storage: only words 0..15 are ever accessed legally.
    logic [31:0] mdl[2][16];
    int          acc_cyc[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts and ends at a negedge.
    task automatic reset_check(input int d);
        rstn[d] = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata[d], 32'h0);
        chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
        rstn[d] = 1'b1;
    endtask

    // One full transaction; starts and ends at a negedge with the DUT idle.
    task automatic txn(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input int stall, output logic [31:0] got);
        int n;
        bit e;
        logic [31:0] er, m;
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        rsp_ready[d] = (stall == 0);
        @(posedge clk);
        #1 acc_cyc[d] = cyc;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        n = 1;
        while (!rsp_valid[d] && n < 40) begin
            chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(wc(d) + 2));

        e  = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth(d)));
        er = (e || wr) ? 32'h0 : mdl[d][addr[5:2]];
        got = rsp_rdata[d];
        chk("rsp_rdata", rsp_rdata[d], er);
        chk("rsp_err", 32'(rsp_err[d]), 32'(e));
        if (!e && wr) begin
            m = mdl[d][addr[5:2]];
            for (int b = 0; b < 4; b++)
                if (be[b]) m[8*b +: 8] = wdata[8*b +: 8];
            mdl[d][addr[5:2]] = m;
        end

        for (int s = 0; s < stall; s++) begin
            // A request presented while stalled in RESP must be ignored.
            if (s == 1 && stall >= 3) begin
                req_valid[d] = 1'b1;
                req_write[d] = 1'b1;
                req_addr[d]  = 32'h0;
                req_be[d]    = 4'hF;
            end else begin
                req_valid[d] = 1'b0;
            end
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid[d]), 32'd1);
            chk("stall_rdata", rsp_rdata[d], er);
            chk("stall_err", 32'(rsp_err[d]), 32'(e));
            chk("stall_req_ready", 32'(req_ready[d]), 32'd0);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        chk("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        chk("post_req_ready", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        int prev, r, w;
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b1;
        end
        @(negedge clk);
        reset_check(0);
        reset_check(1);

        // Known contents for the words the bench uses.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                txn(d, 1'b1, 32'(i * 4), 32'h0, 4'hF, 0, got);

        // Directed on the WAIT_CYCLES=2 instance.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, got);
        chk("wr_rdata_zero", got, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
        chk("raw_deadbeef", got, 32'hDEADBEEF);
        txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, got);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
        chk("be_merge", got, 32'hDE22BE44);
        txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, got);
        txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, got);
        txn(0, 1'b1, 32'(4 * 1024), 32'hA5A5A5A5, 4'hF, 0, got);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, got);
        chk("word0_intact", got, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, got);
        chk("stall_read", got, 32'hDE22BE44);

        // Reset while a write to 0x20 sits in WAIT: write is dropped.
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
        req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'hF;
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset_check(0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, got);
        chk("rst_drop_write", got, 32'h0);

        // WAIT_CYCLES=0: back-to-back reads, one accept every 3 cycles.
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            txn(1, 1'b0, 32'($urandom_range(0, 15) * 4), 32'h0, 4'h0, 0, got);
            if (i > 0) chk("b2b_period", 32'(acc_cyc[1] - prev), 32'd3);
            prev = acc_cyc[1];
        end

        // Randomized traffic on both instances.
        for (int i = 0; i < 120; i++) begin
            int d;
            d = i % 2;
            r = $urandom_range(0, 9);
            w = $urandom_range(0, 15);
            if (r < 7)       a = 32'(w * 4);
            else if (r == 7) a = 32'((depth(d) + $urandom_range(0, 3)) * 4);
            else if (r == 8) a = 32'(w * 4 + $urandom_range(1, 3));
            else             a = $urandom | 32'h8000_0000;
            txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? 3 : 0, got);
        end

        // Final read-back of all modelled words.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                txn(d, 1'b0, 32'(i * 4), 32'h0, 4'h0, 0, got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
